// File: rtl/blinky_multi.sv
// Multi-channel LED pattern engine: per-channel off, solid, blink and
// counted-burst sequencing, programmed through a valid/ready config port.
module blinky_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 24,
  parameter int BURST_W = 8,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CH_W-1:0]    cfg_ch_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [CNT_W-1:0]   cfg_on_i,
  input  logic [CNT_W-1:0]   cfg_off_i,
  input  logic [BURST_W-1:0] cfg_count_i,
  output logic [NUM_CH-1:0]  led_o,
  output logic [NUM_CH-1:0]  busy_o,
  output logic [NUM_CH-1:0]  done_o
);

  typedef enum logic [1:0] {
    IDLE,
    SOLID,
    ON,
    OFF
  } st_e;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_SOLID = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  logic             accept;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;

  assign accept  = cfg_valid_i && cfg_ready_o;
  assign on_len  = (cfg_on_i == '0) ? CNT_W'(1) : cfg_on_i;
  assign off_len = (cfg_off_i == '0) ? CNT_W'(1) : cfg_off_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_ready_o <= 1'b0;
    end else begin
      cfg_ready_o <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(g);

    st_e                st;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   on_r;
    logic [CNT_W-1:0]   off_r;
    logic [BURST_W-1:0] rem;
    logic               burst;
    logic               led_q;
    logic               busy_q;
    logic               done_q;
    logic               hit;

    // Out-of-range channel indices match no slot and are dropped here.
    assign hit       = accept && (cfg_ch_i == IDX);
    assign led_o[g]  = led_q;
    assign busy_o[g] = busy_q;
    assign done_o[g] = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st     <= IDLE;
        cnt    <= '0;
        on_r   <= '0;
        off_r  <= '0;
        rem    <= '0;
        burst  <= 1'b0;
        led_q  <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (hit) begin
        // A new config wins over any completion on this edge.
        done_q <= 1'b0;
        on_r   <= on_len;
        off_r  <= off_len;
        rem    <= cfg_count_i;
        burst  <= (cfg_mode_i == M_BURST);
        cnt    <= '0;
        unique case (1'b1)
          (cfg_mode_i == M_OFF): begin
            st     <= IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
          end
          (cfg_mode_i == M_SOLID): begin
            st     <= SOLID;
            led_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          (cfg_mode_i == M_BURST && cfg_count_i == '0): begin
            st     <= IDLE;
            led_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: begin
            st     <= ON;
            cnt    <= on_len - CNT_W'(1);
            led_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        endcase
      end else begin
        done_q <= 1'b0;
        unique case (st)
          ON: begin
            if (cnt == '0) begin
              st    <= OFF;
              cnt   <= off_r - CNT_W'(1);
              led_q <= 1'b0;
              if (burst) begin
                rem <= rem - BURST_W'(1);
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          OFF: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (burst && rem == '0) begin
              st     <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              st    <= ON;
              cnt   <= on_r - CNT_W'(1);
              led_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blinky_multi.sv
// Bench for blinky_multi: 4-channel and 3-channel instances share stimulus,
// checked each cycle against a phase-arithmetic model plus directed checks.
module tb_blinky_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [23:0] cfg_on = '0;
  logic [23:0] cfg_off = '0;
  logic [7:0]  cfg_count = '0;

  logic        rdy_a, rdy_b;
  logic [3:0]  led_a, busy_a, done_a;
  logic [2:0]  led_b, busy_b, done_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  blinky_multi #(.NUM_CH(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy_a),
    .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
    .cfg_on_i(cfg_on), .cfg_off_i(cfg_off), .cfg_count_i(cfg_count),
    .led_o(led_a), .busy_o(busy_a), .done_o(done_a)
  );

  blinky_multi #(.NUM_CH(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(rdy_b),
    .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
    .cfg_on_i(cfg_on), .cfg_off_i(cfg_off), .cfg_count_i(cfg_count),
    .led_o(led_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Model: each channel remembers its last accepted config and the cycle
  // it was accepted; outputs follow from elapsed cycles modulo the period.
  longint cyc = 0;
  bit     rdy_m = 0;
  int     m_mode [2][4];
  longint m_start[2][4];
  longint m_on   [2][4];
  longint m_off  [2][4];
  longint m_cnt  [2][4];
  int     nch    [2] = '{4, 3};

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_mode[d][c] = 0; m_start[d][c] = 0;
        m_on[d][c] = 1; m_off[d][c] = 1; m_cnt[d][c] = 0;
      end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      rdy_m = 0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 4; c++) m_mode[d][c] = 0;
    end else begin
      cyc++;
      if (cfg_valid && rdy_m) begin
        for (int d = 0; d < 2; d++) begin
          if (int'(cfg_ch) < nch[d]) begin
            m_mode[d][cfg_ch]  = int'(cfg_mode);
            m_start[d][cfg_ch] = cyc;
            m_on[d][cfg_ch]    = (cfg_on == 0) ? 1 : longint'(cfg_on);
            m_off[d][cfg_ch]   = (cfg_off == 0) ? 1 : longint'(cfg_off);
            m_cnt[d][cfg_ch]   = longint'(cfg_count);
          end
        end
      end
      rdy_m = 1;
    end
  end

  task automatic model_ch(input int d, input int c,
                          output bit l, output bit b, output bit dn);
    longint k, p;
    k = cyc - m_start[d][c];
    p = m_on[d][c] + m_off[d][c];
    l = 0; b = 0; dn = 0;
    case (m_mode[d][c])
      1: l = 1;
      2: begin
        l = (k % p) < m_on[d][c];
        b = 1;
      end
      3: begin
        if (m_cnt[d][c] == 0) dn = (k == 0);
        else if (k < m_cnt[d][c] * p) begin
          l = (k % p) < m_on[d][c];
          b = 1;
        end else dn = (k == m_cnt[d][c] * p);
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [3:0] el, eb, ed;
    bit l, b, dn;
    for (int d = 0; d < 2; d++) begin
      el = '0; eb = '0; ed = '0;
      if (rst_n) begin
        for (int c = 0; c < nch[d]; c++) begin
          model_ch(d, c, l, b, dn);
          el[c] = l; eb[c] = b; ed[c] = dn;
        end
      end
      if (d == 0) begin
        chk("a_led", 32'(led_a), 32'(el));
        chk("a_busy", 32'(busy_a), 32'(eb));
        chk("a_done", 32'(done_a), 32'(ed));
        chk("a_ready", 32'(rdy_a), 32'(rst_n && rdy_m));
      end else begin
        chk("b_led", 32'(led_b), 32'(el));
        chk("b_busy", 32'(busy_b), 32'(eb));
        chk("b_done", 32'(done_b), 32'(ed));
        chk("b_ready", 32'(rdy_b), 32'(rst_n && rdy_m));
      end
    end
  end

  // Called at a negedge; the config is accepted on the next rising edge
  // and the task returns at the following negedge (first cycle after).
  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode,
                     input int on, input int off, input int cnt);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = mode;
    cfg_on    = 24'(on);
    cfg_off   = 24'(off);
    cfg_count = 8'(cnt);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin : stim
    int  highs, rises, dcount, dk;
    bit  prev, dseen;

    // Reset
    repeat (5) @(negedge clk);
    chk("rst_led", 32'(led_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_ready", 32'(rdy_a), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy_a), 1);

    // BLINK ch0 on=3 off=5 over 4 periods
    cfg(2'd0, 2'd2, 3, 5, 0);
    highs = 0; rises = 0; prev = 0; dseen = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 3) chk("blink_k3_low", 32'(led_a[0]), 0);
      if (i == 8) chk("blink_k8_high", 32'(led_a[0]), 1);
      chk("blink_busy", 32'(busy_a[0]), 1);
      highs += int'(led_a[0]);
      if (led_a[0] && !prev) rises++;
      prev  = led_a[0];
      dseen |= done_a[0];
      @(negedge clk);
    end
    chk("blink_highs", 32'(highs), 12);
    chk("blink_rises", 32'(rises), 4);
    chk("blink_no_done", 32'(dseen), 0);

    // BURST ch1 on=2 off=2 count=3
    cfg(2'd1, 2'd3, 2, 2, 3);
    highs = 0; rises = 0; prev = 0; dcount = 0; dk = -1;
    for (int i = 0; i < 16; i++) begin
      if (i == 11) chk("burst_busy_k11", 32'(busy_a[1]), 1);
      if (i == 12) chk("burst_busy_k12", 32'(busy_a[1]), 0);
      highs += int'(led_a[1]);
      if (led_a[1] && !prev) rises++;
      prev = led_a[1];
      if (done_a[1]) begin
        dcount++;
        dk = i;
      end
      @(negedge clk);
    end
    chk("burst_highs", 32'(highs), 6);
    chk("burst_rises", 32'(rises), 3);
    chk("burst_done_cnt", 32'(dcount), 1);
    chk("burst_done_k", 32'(dk), 12);

    // BURST count=0 on ch2
    cfg(2'd2, 2'd3, 5, 5, 0);
    chk("b0_done", 32'(done_a[2]), 1);
    chk("b0_led", 32'(led_a[2]), 0);
    chk("b0_busy", 32'(busy_a[2]), 0);
    @(negedge clk);
    chk("b0_done_gone", 32'(done_a[2]), 0);

    // BLINK with zero lengths toggles each cycle
    cfg(2'd2, 2'd2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("zl_toggle", 32'(led_a[2]), 32'((i % 2) == 0));
      @(negedge clk);
    end

    // Abort a burst on ch3 with SOLID six cycles after acceptance
    cfg(2'd3, 2'd3, 4, 4, 4);
    repeat (5) @(negedge clk);
    chk("abort_pre_led", 32'(led_a[3]), 0);
    chk("abort_pre_busy", 32'(busy_a[3]), 1);
    cfg(2'd3, 2'd1, 0, 0, 0);
    chk("abort_led", 32'(led_a[3]), 1);
    chk("abort_busy", 32'(busy_a[3]), 0);
    dseen = 0;
    for (int i = 0; i < 40; i++) begin
      dseen |= done_a[3];
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dseen), 0);

    // Config lands on the edge where a burst would complete
    cfg(2'd1, 2'd3, 1, 1, 1);
    @(negedge clk);
    chk("prio_pre_led", 32'(led_a[1]), 0);
    cfg(2'd1, 2'd1, 0, 0, 0);
    chk("prio_no_done", 32'(done_a[1]), 0);
    chk("prio_led", 32'(led_a[1]), 1);

    // Independence and out-of-range channel on the 3-channel instance
    cfg(2'd0, 2'd2, 1, 1, 0);
    cfg(2'd1, 2'd1, 0, 0, 0);
    cfg(2'd2, 2'd0, 0, 0, 0);
    cfg(2'd3, 2'd2, 2, 2, 0);
    chk("ind_b_led", 32'(led_b), 32'h2);
    chk("ind_b_busy", 32'(busy_b), 32'h1);
    chk("ind_a_led", 32'(led_a), 32'ha);
    chk("ind_a_busy", 32'(busy_a), 32'h9);
    chk("ind_b_ready", 32'(rdy_b), 1);
    @(negedge clk);
    chk("ind_b_led2", 32'(led_b), 32'h3);
    chk("ind_a_led2", 32'(led_a), 32'hb);

    // Reset mid-sequence
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_ready", 32'(rdy_a), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_up", 32'(rdy_b), 1);
    chk("mid_rst_led_b", 32'(led_b), 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
